// File: rtl/sw_pkg.sv
// Shared constants for the Smith-Waterman sequence loader: default length,
// 2-bit base encoding and the loader state enumeration.
package sw_pkg;

  localparam int LEN_DEF = 256;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/sw_seq_buf.sv
// LEN x 2-bit sequence storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module sw_seq_buf
  import sw_pkg::*;
#(
  parameter int DEPTH = LEN_DEF,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sw_seq_loader.sv
// Loads two ASCII base sequences (S, T) from a host, then streams them
// element-by-element to a Smith-Waterman core and captures its max score.
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int LEN  = LEN_DEF,
  parameter int MAXW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sel,
  input  logic [7:0]      in_char,
  output logic            sw_valid,
  output logic [1:0]      sw_data_s,
  output logic [1:0]      sw_data_t,
  input  logic            sw_finish,
  input  logic [MAXW-1:0] sw_max,
  output logic [MAXW-1:0] result,
  output logic            result_valid,
  output logic            err
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CNT_W = $clog2(LEN) + 1;

  // Returns {legal, code}; only uppercase A/C/G/T are legal.
  function automatic logic [2:0] encode(input logic [7:0] ch);
    case (ch)
      8'h41:   encode = {1'b1, BASE_A};
      8'h43:   encode = {1'b1, BASE_C};
      8'h47:   encode = {1'b1, BASE_G};
      8'h54:   encode = {1'b1, BASE_T};
      default: encode = 3'b000;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_s, cnt_t;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_addr;
  logic [1:0]       rd_s, rd_t;
  logic [1:0]       enc_code;
  logic             enc_legal;
  logic             s_full, t_full;
  logic             accept, we_s, we_t;
  logic             start_stream, last_elem, finish;
  logic             vld_p1;
  logic [1:0]       data_s_p1, data_t_p1;

  assign {enc_legal, enc_code} = encode(in_char);
  assign s_full = (cnt_s == CNT_W'(LEN));
  assign t_full = (cnt_t == CNT_W'(LEN));

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    start_stream = 1'b0;
    last_elem    = 1'b0;
    finish       = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = in_sel ? !t_full : !s_full;
        if (s_full && t_full) begin
          state_d      = STREAM;
          start_stream = 1'b1;
        end
      end
      STREAM: begin
        if (idx == IDX_W'(LEN - 1)) begin
          state_d   = WAIT;
          last_elem = 1'b1;
        end
      end
      WAIT: begin
        if (sw_finish) begin
          state_d = LOAD;
          finish  = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Illegal characters complete the handshake but are never written.
  assign accept = in_valid && in_ready;
  assign we_s   = accept && enc_legal && !in_sel;
  assign we_t   = accept && enc_legal && in_sel;

  // Read one element ahead so the registered output shows element idx.
  assign rd_addr = (state_q == STREAM) ? idx + IDX_W'(1) : '0;

  sw_seq_buf #(.DEPTH(LEN), .AW(IDX_W)) u_buf_s (
    .clk   (clk),
    .we    (we_s),
    .waddr (cnt_s[IDX_W-1:0]),
    .wdata (enc_code),
    .raddr (rd_addr),
    .rdata (rd_s)
  );

  sw_seq_buf #(.DEPTH(LEN), .AW(IDX_W)) u_buf_t (
    .clk   (clk),
    .we    (we_t),
    .waddr (cnt_t[IDX_W-1:0]),
    .wdata (enc_code),
    .raddr (rd_addr),
    .rdata (rd_t)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // p1: registered stream outputs, load counters and score capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_s        <= '0;
      cnt_t        <= '0;
      idx          <= '0;
      vld_p1       <= 1'b0;
      data_s_p1    <= 2'b00;
      data_t_p1    <= 2'b00;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (finish) begin
        cnt_s <= '0;
        cnt_t <= '0;
      end else begin
        if (we_s) cnt_s <= cnt_s + CNT_W'(1);
        if (we_t) cnt_t <= cnt_t + CNT_W'(1);
      end
      if (accept && !enc_legal) err <= 1'b1;
      result_valid <= finish;
      if (finish) result <= sw_max;
      if (start_stream) begin
        vld_p1    <= 1'b1;
        data_s_p1 <= rd_s;
        data_t_p1 <= rd_t;
        idx       <= '0;
      end else if (state_q == STREAM && !last_elem) begin
        vld_p1    <= 1'b1;
        data_s_p1 <= rd_s;
        data_t_p1 <= rd_t;
        idx       <= idx + IDX_W'(1);
      end else begin
        vld_p1    <= 1'b0;
        data_s_p1 <= 2'b00;
        data_t_p1 <= 2'b00;
        idx       <= '0;
      end
    end
  end

  assign sw_valid  = vld_p1;
  assign sw_data_s = data_s_p1;
  assign sw_data_t = data_t_p1;

endmodule
